// File: rtl/round_judge.sv
// Two-player round arbiter: decides who answered correctly first (or draw/timeout),
// tracks both players' HP and flags game over to the controller.
module round_judge #(
  parameter int HP_INIT     = 3,
  parameter int HP_W        = 3,
  parameter int DMG         = 1,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int CNT_W       = 29
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      STATE,
  input  logic            ANS_L,
  input  logic            OK_L,
  input  logic            ANS_R,
  input  logic            OK_R,
  output logic [1:0]      JUDG,
  output logic            WRONG,
  output logic            TIMEOUT,
  output logic [1:0]      HP_OUT,
  output logic [HP_W-1:0] HP_L,
  output logic [HP_W-1:0] HP_R
);

  localparam logic [3:0]       ST_READY = 4'b0010;
  localparam logic [3:0]       ST_INPUT = 4'b0100;
  localparam logic [HP_W-1:0]  HP_RST   = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]  DMG_V    = HP_W'(DMG);
  localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] timer;

  logic            is_input, val_l, val_r, win_l, win_r;
  logic [HP_W-1:0] hp_l_hit, hp_r_hit;

  always_comb begin
    is_input = (STATE == ST_INPUT);
    val_l    = ANS_L && is_input && (fsm == ARMED);
    val_r    = ANS_R && is_input && (fsm == ARMED);
    win_l    = val_l && OK_L;
    win_r    = val_r && OK_R;
    // saturating damage toward zero
    hp_l_hit = (HP_L > DMG_V) ? HP_L - DMG_V : '0;
    hp_r_hit = (HP_R > DMG_V) ? HP_R - DMG_V : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm     <= IDLE;
      timer   <= '0;
      JUDG    <= 2'b00;
      WRONG   <= 1'b0;
      TIMEOUT <= 1'b0;
      HP_OUT  <= 2'b00;
      HP_L    <= HP_RST;
      HP_R    <= HP_RST;
    end else begin
      WRONG   <= 1'b0;
      TIMEOUT <= 1'b0;
      case (fsm)
        IDLE: begin
          if (is_input) begin
            timer <= '0;
            fsm   <= ARMED;
          end
        end
        ARMED: begin
          if (win_l && win_r) begin
            JUDG <= 2'b11;
            fsm  <= HOLD;
          end else if (win_l) begin
            JUDG <= 2'b01;
            HP_R <= hp_r_hit;
            if (hp_r_hit == '0) HP_OUT <= 2'b01;
            fsm  <= HOLD;
          end else if (win_r) begin
            JUDG <= 2'b10;
            HP_L <= hp_l_hit;
            if (hp_l_hit == '0) HP_OUT <= 2'b10;
            fsm  <= HOLD;
          end else if (timer == T_LAST) begin
            JUDG    <= 2'b11;
            TIMEOUT <= 1'b1;
            fsm     <= HOLD;
          end else begin
            timer <= timer + 1'b1;
            WRONG <= val_l && !OK_L;
          end
        end
        HOLD: begin
          if (STATE == ST_READY) begin
            JUDG <= 2'b00;
            fsm  <= IDLE;
            // game over: start the next game with fresh HP
            if (HP_OUT != 2'b00) begin
              HP_L   <= HP_RST;
              HP_R   <= HP_RST;
              HP_OUT <= 2'b00;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Scoreboard bench for round_judge: a behavioural game model predicts every cycle's
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_round_judge;
  localparam int HP_INIT = 3;
  localparam int DMG     = 1;
  localparam int TCYC    = 20;
  localparam logic [3:0] S_READY = 4'b0010, S_QUEST = 4'b0011, S_INPUT = 4'b0100;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [3:0] STATE = 4'b0000;
  logic       ANS_L = 1'b0, OK_L = 1'b0, ANS_R = 1'b0, OK_R = 1'b0;
  logic [1:0] JUDG, HP_OUT;
  logic       WRONG, TIMEOUT;
  logic [2:0] HP_L, HP_R;

  round_judge #(.HP_INIT(HP_INIT), .HP_W(3), .DMG(DMG), .TIMEOUT_CYC(TCYC), .CNT_W(29)) dut (
    .CLK(CLK), .RST(RST), .STATE(STATE), .ANS_L(ANS_L), .OK_L(OK_L), .ANS_R(ANS_R),
    .OK_R(OK_R), .JUDG(JUDG), .WRONG(WRONG), .TIMEOUT(TIMEOUT), .HP_OUT(HP_OUT),
    .HP_L(HP_L), .HP_R(HP_R));

  always #5 CLK = ~CLK;

  typedef struct {int judg; int wrong; int tmo; int over; int hl; int hr;} snap_t;
  snap_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // behavioural game model
  bit round_open = 0, verdict_shown = 0;
  int elapsed = 0;
  snap_t m = '{0, 0, 0, 0, HP_INIT, HP_INIT};

  function automatic int hit(int hp);
    return (hp > DMG) ? hp - DMG : 0;
  endfunction

  task automatic model_eval();
    bit in_input, vl, vr, cl, cr, decided;
    m.wrong = 0;
    m.tmo   = 0;
    if (RST) begin
      round_open = 0; verdict_shown = 0; elapsed = 0;
      m = '{0, 0, 0, 0, HP_INIT, HP_INIT};
    end else if (verdict_shown) begin
      if (STATE == S_READY) begin
        verdict_shown = 0;
        m.judg = 0;
        if (m.over != 0) begin m.over = 0; m.hl = HP_INIT; m.hr = HP_INIT; end
      end
    end else if (round_open) begin
      in_input = (STATE == S_INPUT);
      vl = ANS_L && in_input;  vr = ANS_R && in_input;
      cl = vl && OK_L;         cr = vr && OK_R;
      decided = 1;
      if (cl && cr)                m.judg = 3;
      else if (cl) begin           m.judg = 1; m.hr = hit(m.hr); end
      else if (cr) begin           m.judg = 2; m.hl = hit(m.hl); end
      else if (elapsed + 1 == TCYC) begin m.judg = 3; m.tmo = 1; end
      else begin
        decided = 0;
        elapsed++;
        m.wrong = (vl && !OK_L) ? 1 : 0;
      end
      if (decided) begin
        round_open = 0; verdict_shown = 1;
        if (m.hr == 0) m.over = 1;
        else if (m.hl == 0) m.over = 2;
      end
    end else if (STATE == S_INPUT) begin
      round_open = 1;
      elapsed = 0;
    end
    exp_q.push_back(m);
  endtask

  task automatic step();
    model_eval();
    @(posedge CLK);
    #1;
    ANS_L = 1'b0;
    ANS_R = 1'b0;
  endtask

  always @(negedge CLK) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("judg",    int'(JUDG),    e.judg);
      chk("wrong",   int'(WRONG),   e.wrong);
      chk("timeout", int'(TIMEOUT), e.tmo);
      chk("hp_out",  int'(HP_OUT),  e.over);
      chk("hp_l",    int'(HP_L),    e.hl);
      chk("hp_r",    int'(HP_R),    e.hr);
    end
  end

  task automatic do_reset();
    RST = 1'b1; STATE = 4'b0000; step(); step(); RST = 1'b0;
  endtask

  task automatic arm();
    STATE = S_INPUT; step();
  endtask

  initial begin
    do_reset();
    chk("rst_judg", int'(JUDG), 0);
    chk("rst_hp_l", int'(HP_L), HP_INIT);
    chk("rst_hp_r", int'(HP_R), HP_INIT);

    // local win on the 5th cycle
    arm(); step(); step(); step();
    ANS_L = 1; OK_L = 1; step();
    chk("win_l_judg", int'(JUDG), 1);
    chk("win_l_hp_r", int'(HP_R), 2);
    chk("win_l_hp_l", int'(HP_L), 3);
    chk("win_l_over", int'(HP_OUT), 0);
    STATE = S_READY; step();
    chk("ready_judg", int'(JUDG), 0);

    // simultaneous correct answers
    do_reset(); arm();
    ANS_L = 1; OK_L = 1; ANS_R = 1; OK_R = 1; step();
    chk("draw_judg", int'(JUDG), 3);
    chk("draw_hp_l", int'(HP_L), 3);
    chk("draw_hp_r", int'(HP_R), 3);
    STATE = S_READY; step();

    // wrong local then remote win
    arm(); ANS_L = 1; OK_L = 0; step();
    chk("wrong_hi", int'(WRONG), 1);
    chk("wrong_judg", int'(JUDG), 0);
    step();
    chk("wrong_lo", int'(WRONG), 0);
    ANS_R = 1; OK_R = 1; step();
    chk("win_r_judg", int'(JUDG), 2);
    chk("win_r_hp_l", int'(HP_L), 2);
    STATE = S_READY; step();

    // timeout after exactly TCYC armed cycles
    do_reset(); arm();
    for (int i = 0; i < TCYC - 1; i++) step();
    chk("tmo_early", int'(TIMEOUT), 0);
    step();
    chk("tmo_pulse", int'(TIMEOUT), 1);
    chk("tmo_judg", int'(JUDG), 3);
    step();
    chk("tmo_once", int'(TIMEOUT), 0);
    STATE = S_READY; step();

    // correct answer in the last timer cycle beats timeout
    arm();
    for (int i = 0; i < TCYC - 1; i++) step();
    ANS_L = 1; OK_L = 1; step();
    chk("late_win_judg", int'(JUDG), 1);
    chk("late_win_tmo", int'(TIMEOUT), 0);
    STATE = S_READY; step();

    // three local wins end the game
    do_reset();
    for (int k = 0; k < 3; k++) begin
      arm(); ANS_L = 1; OK_L = 1; step();
      if (k < 2) begin STATE = S_READY; step(); end
    end
    chk("go_hp_r", int'(HP_R), 0);
    chk("go_over", int'(HP_OUT), 1);
    STATE = S_READY; step();
    chk("reload_hp_r", int'(HP_R), 3);
    chk("reload_over", int'(HP_OUT), 0);

    // reset during HOLD with HP_R=1
    for (int k = 0; k < 2; k++) begin
      arm(); ANS_L = 1; OK_L = 1; step(); STATE = S_READY; step();
    end
    arm(); ANS_L = 1; OK_L = 1; ANS_R = 1; OK_R = 1; step();
    chk("hold_hp_r1", int'(HP_R), 1);
    RST = 1; step(); RST = 0;
    chk("rst_hold_hp_r", int'(HP_R), 3);
    chk("rst_hold_judg", int'(JUDG), 0);
    STATE = S_QUEST; ANS_L = 1; OK_L = 1; step();
    chk("quest_ignored", int'(JUDG), 0);

    // randomized rounds
    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(0, 29) == 0) begin RST = 1; step(); RST = 0; end
      STATE = S_QUEST;
      for (int i = $urandom_range(0, 2); i > 0; i--) begin
        ANS_L = ($urandom_range(0, 3) == 0); OK_L = $urandom_range(0, 1);
        step();
      end
      for (int i = $urandom_range(1, TCYC + 6); i > 0; i--) begin
        STATE = ($urandom_range(0, 7) == 0) ? S_QUEST : S_INPUT;
        ANS_L = ($urandom_range(0, 5) == 0); OK_L = $urandom_range(0, 1);
        ANS_R = ($urandom_range(0, 5) == 0); OK_R = $urandom_range(0, 1);
        step();
      end
      STATE = ($urandom_range(0, 4) == 0) ? 4'b1111 : S_READY;
      step();
      STATE = S_READY;
      for (int i = $urandom_range(0, 1); i > 0; i--) step();
    end

    STATE = 4'b0000;
    step();
    @(negedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/round_judge.md
# round_judge

Two-player round arbiter for the factorization game. It watches the local and remote answer-submit pulses while the game controller is in INPUT. It decides who answered correctly first, or declares a draw or timeout, and keeps both players' HP. It drives the controller's judgement input (JUDG), the wrong-answer input (WRONG), and the game-over input (HP_OUT, the controller's HP_IN).

## Interface
- HP_INIT, 3: HP loaded for each player at reset and at the start of a new game.
- HP_W, 3: width of the HP counters. HP_INIT and DMG must each fit in this width.
- DMG, 1: HP subtracted from the loser of a round. Subtraction saturates at 0.
- TIMEOUT_CYC, 500_000_000: round time limit, in CLK cycles (10 s at 50 MHz).
- CNT_W, 29: width of the round timer. It must hold TIMEOUT_CYC-1.
- CLK  in  1  system clock (50 MHz); all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- STATE  in  4  controller state code: READY=4'b0010, QUESTION=4'b0011, INPUT=4'b0100; other codes are treated as "not INPUT".
- ANS_L  in  1  local answer-submit, one-cycle pulse.
- OK_L  in  1  local answer correct; sampled only when ANS_L=1.
- ANS_R  in  1  remote answer-submit, one-cycle pulse, already synchronised.
- OK_R  in  1  remote answer correct; sampled only when ANS_R=1.
- JUDG  out  2  round result: 00 none, 01 local won round, 10 remote won round, 11 draw.
- WRONG  out  1  one-cycle pulse, local submitted an incorrect answer.
- TIMEOUT  out  1  one-cycle pulse, round expired.
- HP_OUT  out  2  00 game running, 01 local won game, 10 remote won game.
- HP_L  out  HP_W  local HP.
- HP_R  out  HP_W  remote HP.

## Operation
- Reset values: FSM=IDLE, timer=0, JUDG=00, WRONG=0, TIMEOUT=0, HP_OUT=00, HP_L=HP_R=HP_INIT.
- Valid answer: ANS_x=1 in a cycle while the FSM is ARMED and STATE==INPUT. Submits in any other cycle are ignored.
- IDLE:
  - When STATE==INPUT, clear the timer and go to ARMED.
- ARMED: the timer increments every cycle, including cycles with STATE==QUESTION. Events are evaluated in priority order each cycle:
  1. Valid correct answers from both players in the same cycle: JUDG=11, no HP change, go to HOLD.
  2. Valid correct local answer only: JUDG=01, HP_R -= DMG (saturating), go to HOLD.
  3. Valid correct remote answer only: JUDG=10, HP_L -= DMG (saturating), go to HOLD.
  4. Timer == TIMEOUT_CYC-1: JUDG=11, TIMEOUT=1 for one cycle, go to HOLD.
  5. Valid incorrect local answer (not covered by 1-3): WRONG=1 for one cycle, stay ARMED, timer keeps running.
  - A valid incorrect remote answer produces no output.
  - A correct answer wins over the timeout in the same cycle.
- HOLD:
  - JUDG is held and further submits are ignored.
  - If HP_L or HP_R reached 0 on the transition into HOLD, HP_OUT is set on that same edge: 01 if HP_R==0, 10 if HP_L==0.
  - On STATE==READY: JUDG=00, go to IDLE.
  - If HP_OUT!=00 at that point, also reload HP_L=HP_R=HP_INIT and clear HP_OUT to 00.
- Only one HP counter changes per round, so HP_L and HP_R can never both reach 0.
- RST in any state forces reset values on the next edge, including in the middle of a round or during HOLD.

## Timing
- Every output is a register.
- JUDG, HP_L/HP_R, HP_OUT, WRONG and TIMEOUT update on the edge that samples the deciding input. Latency is 1 cycle from the input to the visible output.
- JUDG is stable from HOLD entry until the edge after STATE==READY is first sampled. The controller may sample it on any cycle in between.
- IDLE to ARMED takes 1 cycle after STATE==INPUT is sampled. A submit in the same cycle as that STATE==INPUT sample is ignored.
- A timeout round lasts exactly TIMEOUT_CYC cycles of ARMED: the timer runs 0 to TIMEOUT_CYC-1, and TIMEOUT pulses on the edge after the count TIMEOUT_CYC-1 is sampled.
- WRONG and TIMEOUT never stay high for two consecutive cycles.

## Test plan
- Reset, then STATE=INPUT, then ANS_L=1/OK_L=1 at cycle 5 -> JUDG=01 next cycle, HP_R=2, HP_L=3, HP_OUT=00; STATE=READY -> JUDG=00, FSM=IDLE.
- ANS_L/OK_L and ANS_R/OK_R both asserted in the same cycle -> JUDG=11, HP_L=HP_R=3.
- ANS_L=1/OK_L=0 -> WRONG high for exactly one cycle, JUDG stays 00; a later ANS_R/OK_R -> JUDG=10, HP_L=2.
- Bench with TIMEOUT_CYC=20 and no answers -> TIMEOUT pulse and JUDG=11 exactly 20 cycles after ARMED entry. A correct ANS_L in the last timer cycle -> JUDG=01, no TIMEOUT pulse.
- Three local wins -> HP_R=0 and HP_OUT=01 on the third judgement edge; STATE=READY -> HP_L=HP_R=3, HP_OUT=00.
- RST asserted in HOLD with HP_R=1 -> next cycle all outputs at reset values, HP_R=3; a submit while STATE=QUESTION -> ignored.
